cluster_mem_responder: RTL and testbench

Memory-side responder for the hart cluster's request port. It accepts one physical-address request at a time from the cluster arbiter and asserts busy while the request is in flight. It fetches or updates one 128-bit line in backing memory over a req/ack line interface, and returns the line on the instruction or data return bus. Sub-line stores are done as read-modify-write because backing memory has no byte mask.

---
 rtl/cluster_mem_responder_pkg.sv | 27 ++
 rtl/cluster_mem_responder_line_store_merge.sv | 32 +++
 rtl/cluster_mem_responder.sv | 182 ++++++++++++++++++
 tb/tb_cluster_mem_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cluster_mem_responder_pkg.sv
// Shared types and constants for the cluster memory responder.
package rvpc_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_MERGE = 3'd2,
        ST_WR    = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int LINE_BYTES = 16;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            SZ_W:    size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/cluster_mem_responder_line_store_merge.sv
// Combinational store-into-line merge plus alignment check for one request.
module line_store_merge
    import rvpc_mem_pkg::*;
#(
    parameter int LINE_W = 128
) (
    input  logic [LINE_W-1:0] i_line,
    input  logic [3:0]        i_off,
    input  logic [1:0]        i_size,
    input  logic [31:0]       i_wdata,
    output logic [LINE_W-1:0] o_line,
    output logic              o_misalign
);

    logic [2:0] w_nb;

    assign w_nb       = size_bytes(i_size);
    assign o_misalign = (i_size == SZ_H && i_off[0]) ||
                        (i_size == SZ_W && i_off[1:0] != 2'd0) ||
                        (i_size == 2'd3);

    // An aligned access never crosses the line, so byte b takes store byte (b - off).
    for (genvar b = 0; b < LINE_W / 8; b++) begin : g_byte
        logic [4:0] w_rel;
        logic       w_hit;
        assign w_rel = 5'(b) - {1'b0, i_off};
        assign w_hit = (5'(b) >= {1'b0, i_off}) && (w_rel < {2'b00, w_nb});
        assign o_line[8*b +: 8] = w_hit ? i_wdata[{w_rel[1:0], 3'b000} +: 8]
                                        : i_line[8*b +: 8];
    end

endmodule

// File: rtl/cluster_mem_responder.sv
// Memory-side responder: one line fetch/update per request, RMW for stores.
// Optional single-entry line buffer enabled by CLUSTER_MEM_LINE_BUF_EN.
module cluster_mem_responder
    import rvpc_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_ctrl,
    input  logic [31:0]       i_req_wdata,
    input  logic              i_req_iscode,
    input  logic              i_buf_flush,
    output logic              o_busy,
    output logic              o_resp_valid,
    output logic              o_resp_err,
    output logic [LINE_W-1:0] o_insn_data,
    output logic [LINE_W-1:0] o_data_data,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-5:0] o_mem_addr,
    output logic [LINE_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [LINE_W-1:0] i_mem_rdata
);

    state_t r_state, w_next;

    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [1:0]        r_size;
    logic [31:0]       r_wdata;
    logic              r_iscode;
    logic [LINE_W-1:0] r_line;
    logic              r_busy, r_resp_valid, r_resp_err;
    logic [LINE_W-1:0] r_insn_data, r_data_data, r_mem_wdata;

    logic              w_idle, w_accept, w_misalign, w_err, w_hit;
    logic [3:0]        w_off;
    logic [1:0]        w_size;
    logic [LINE_W-1:0] w_merged, w_buf_line, w_ld_line;
    logic              w_ld, w_code;
    logic              w_unused;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && i_req_valid;
    assign w_off    = w_idle ? i_req_addr[3:0] : r_addr[3:0];
    assign w_size   = w_idle ? i_req_ctrl[1:0] : r_size;
    assign w_err    = w_accept && w_misalign;
    assign w_unused = i_req_ctrl[2] ^ i_buf_flush;

    line_store_merge #(.LINE_W(LINE_W)) u_merge (
        .i_line     (r_line),
        .i_off      (w_off),
        .i_size     (w_size),
        .i_wdata    (r_wdata),
        .o_line     (w_merged),
        .o_misalign (w_misalign)
    );

`ifdef CLUSTER_MEM_LINE_BUF_EN
    logic              r_buf_vld;
    logic [ADDR_W-5:0] r_buf_tag;
    logic [LINE_W-1:0] r_buf_line;

    // A flush in the request cycle forces a miss so stale data is never returned.
    assign w_hit      = r_buf_vld && !i_buf_flush && (r_buf_tag == i_req_addr[ADDR_W-1:4]);
    assign w_buf_line = r_buf_line;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_buf_vld  <= 1'b0;
            r_buf_tag  <= '0;
            r_buf_line <= '0;
        end else if (i_buf_flush) begin
            r_buf_vld <= 1'b0;
        end else if (i_mem_ack && (r_state == ST_RD || r_state == ST_WR)) begin
            r_buf_vld  <= 1'b1;
            r_buf_tag  <= r_addr[ADDR_W-1:4];
            r_buf_line <= (r_state == ST_RD) ? i_mem_rdata : r_line;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_buf_line = '0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_req_valid) begin
                if (w_misalign)  w_next = ST_RESP;
                else if (w_hit)  w_next = i_req_we ? ST_MERGE : ST_RESP;
                else             w_next = ST_RD;
            end
            ST_RD:    if (i_mem_ack) w_next = r_we ? ST_MERGE : ST_RESP;
            ST_MERGE: w_next = ST_WR;
            ST_WR:    if (i_mem_ack) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Successful completions load a return bus on the edge into RESP.
    always_comb begin
        w_ld      = 1'b0;
        w_ld_line = i_mem_rdata;
        case (r_state)
            ST_IDLE: if (w_accept && !w_misalign && w_hit && !i_req_we) begin
                w_ld      = 1'b1;
                w_ld_line = w_buf_line;
            end
            ST_RD: if (i_mem_ack && !r_we) w_ld = 1'b1;
            ST_WR: if (i_mem_ack) begin
                w_ld      = 1'b1;
                w_ld_line = r_line;
            end
            default: ;
        endcase
    end

    assign w_code = w_idle ? (i_req_iscode && !i_req_we) : (r_iscode && !r_we);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_size       <= 2'd0;
            r_wdata      <= '0;
            r_iscode     <= 1'b0;
            r_line       <= '0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_insn_data  <= '0;
            r_data_data  <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_resp_valid <= w_ld || w_err;
            r_resp_err   <= w_err;
            if (w_accept) begin
                r_addr   <= i_req_addr;
                r_we     <= i_req_we;
                r_size   <= i_req_ctrl[1:0];
                r_wdata  <= i_req_wdata;
                r_iscode <= i_req_iscode;
                r_busy   <= 1'b1;
                if (w_hit) r_line <= w_buf_line;
            end
            if (r_state == ST_RD && i_mem_ack) r_line <= i_mem_rdata;
            if (r_state == ST_MERGE) begin
                r_line      <= w_merged;
                r_mem_wdata <= w_merged;
            end
            if (r_state == ST_RESP) r_busy <= 1'b0;
            if (w_ld) begin
                if (w_code) r_insn_data <= w_ld_line;
                else        r_data_data <= w_ld_line;
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_resp_err;
    assign o_insn_data  = r_insn_data;
    assign o_data_data  = r_data_data;
    assign o_mem_req    = (r_state == ST_RD) || (r_state == ST_WR);
    assign o_mem_we     = (r_state == ST_WR);
    assign o_mem_addr   = r_addr[ADDR_W-1:4];
    assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_cluster_mem_responder.sv
// Directed bench for cluster_mem_responder; inputs driven and outputs sampled on negedge.
module tb_cluster_mem_responder;

    logic         CLK = 1'b0;
    logic         RST;
    logic         i_req_valid, i_req_we, i_req_iscode, i_buf_flush, i_mem_ack;
    logic [31:0]  i_req_addr, i_req_wdata;
    logic [2:0]   i_req_ctrl;
    logic [127:0] i_mem_rdata;
    logic         o_busy, o_resp_valid, o_resp_err, o_mem_req, o_mem_we;
    logic [127:0] o_insn_data, o_data_data, o_mem_wdata;
    logic [27:0]  o_mem_addr;

    int n_chk = 0;
    int n_err = 0;

    logic         m_we;
    logic [27:0]  m_addr;
    logic [127:0] m_wdata;

    localparam logic [127:0] L1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] L2 = 128'hCAFEF00D_12345678_9ABCDEF0_55AA55AA;

    always #5 CLK = ~CLK;

    cluster_mem_responder dut (
        .CLK(CLK), .RST(RST),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_we(i_req_we),
        .i_req_ctrl(i_req_ctrl), .i_req_wdata(i_req_wdata), .i_req_iscode(i_req_iscode),
        .i_buf_flush(i_buf_flush),
        .o_busy(o_busy), .o_resp_valid(o_resp_valid), .o_resp_err(o_resp_err),
        .o_insn_data(o_insn_data), .o_data_data(o_data_data),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Present a request for one cycle; returns on the negedge after the accept edge.
    task automatic req(input logic [31:0] a, input logic we, input logic [2:0] ctrl,
                       input logic [31:0] wd, input logic code);
        i_req_valid = 1'b1; i_req_addr = a; i_req_we = we;
        i_req_ctrl = ctrl; i_req_wdata = wd; i_req_iscode = code;
        tick();
        i_req_valid = 1'b0;
    endtask

    // Wait for o_mem_req, hold off 'wt' cycles, then pulse ack with 'rd'.
    task automatic serve(input string tag, input int wt, input logic [127:0] rd);
        int n;
        n = 0;
        while (!o_mem_req && n < 50) begin tick(); n++; end
        if (!o_mem_req) begin
            chk({tag, "_req_tmo"}, 0, 1);
            return;
        end
        repeat (wt) tick();
        m_we = o_mem_we; m_addr = o_mem_addr; m_wdata = o_mem_wdata;
        i_mem_ack = 1'b1; i_mem_rdata = rd;
        tick();
        i_mem_ack = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        i_req_valid = 0; i_req_addr = 0; i_req_we = 0; i_req_ctrl = 0;
        i_req_wdata = 0; i_req_iscode = 0; i_buf_flush = 0; i_mem_ack = 0; i_mem_rdata = 0;
        tick(); tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_vld", o_resp_valid, 0);
        chk("rst_memreq", o_mem_req, 0);
        chk("rst_data", o_data_data, 0);
        RST = 1'b0;
        tick();

        // word load, 3 wait cycles
        req(32'h8000_0014, 0, 3'd2, 0, 0);
        chk("ld_busy", o_busy, 1);
        serve("ld", 3, L1);
        chk("ld_addr", m_addr, 28'h800_0001);
        chk("ld_we", m_we, 0);
        chk("ld_vld", o_resp_valid, 1);
        chk("ld_err", o_resp_err, 0);
        chk("ld_data", o_data_data, L1);
        chk("ld_insn", o_insn_data, 0);
        chk("ld_busy_resp", o_busy, 1);
        tick();
        chk("ld_vld_pulse", o_resp_valid, 0);
        chk("ld_busy_drop", o_busy, 0);

        // fetch
        req(32'h8000_0020, 0, 3'd2, 0, 1);
        serve("fe", 0, L2);
        chk("fe_addr", m_addr, 28'h800_0002);
        chk("fe_vld", o_resp_valid, 1);
        chk("fe_insn", o_insn_data, L2);
        chk("fe_data", o_data_data, L1);
        tick();

        // byte store 0xAB at offset 7 over all-0x11
        req(32'h8000_0007, 1, 3'd0, 32'h0000_00AB, 0);
        serve("sb_rd", 1, {16{8'h11}});
        chk("sb_rd_we", m_we, 0);
        serve("sb_wr", 2, '0);
        chk("sb_wr_we", m_we, 1);
        chk("sb_wr_addr", m_addr, 28'h800_0000);
        chk("sb_wr_line", m_wdata, 128'h11111111_11111111_AB111111_11111111);
        chk("sb_vld", o_resp_valid, 1);
        chk("sb_data", o_data_data, 128'h11111111_11111111_AB111111_11111111);
        tick();

        // word store into the top lane, code flag set (treated as store)
        req(32'h8000_003C, 1, 3'd2, 32'hDEAD_BEEF, 1);
        serve("sw_rd", 0, {16{8'h22}});
        serve("sw_wr", 0, '0);
        chk("sw_wr_line", m_wdata, 128'hDEADBEEF_22222222_22222222_22222222);
        chk("sw_data", o_data_data, 128'hDEADBEEF_22222222_22222222_22222222);
        chk("sw_insn", o_insn_data, L2);
        tick();

        // half store at offset 4 over L1
        req(32'h8000_0044, 1, 3'd1, 32'h0000_BEEF, 0);
        serve("sh_rd", 0, L1);
        serve("sh_wr", 0, '0);
        chk("sh_wr_line", m_wdata, 128'h0F0E0D0C_0B0A0908_0706BEEF_03020100);
        tick();

        // misaligned half store: error, no memory traffic
        req(32'h8000_0041, 1, 3'd1, 32'h1234, 0);
        chk("mis_memreq", o_mem_req, 0);
        chk("mis_vld", o_resp_valid, 1);
        chk("mis_err", o_resp_err, 1);
        chk("mis_busy", o_busy, 1);
        tick();
        chk("mis_busy_drop", o_busy, 0);
        chk("mis_err_drop", o_resp_err, 0);
        chk("mis_memreq2", o_mem_req, 0);

        // misaligned word load and reserved size
        req(32'h8000_0042, 0, 3'd2, 0, 0);
        chk("misw_err", o_resp_err, 1);
        tick();
        req(32'h8000_0040, 0, 3'd3, 0, 0);
        chk("rsv_err", o_resp_err, 1);
        chk("rsv_memreq", o_mem_req, 0);
        tick();

        // reset while in WR
        req(32'h8000_0050, 1, 3'd0, 32'h55, 0);
        serve("rs_rd", 0, L1);
        tick();
        chk("rs_in_wr", {o_mem_req, o_mem_we}, 2'b11);
        #1 RST = 1'b1;
        #1;
        chk("rs_memreq_async", o_mem_req, 0);
        chk("rs_busy", o_busy, 0);
        chk("rs_data", o_data_data, 0);
        tick();
        RST = 1'b0;
        i_mem_ack = 1'b1;
        tick();
        i_mem_ack = 1'b0;
        chk("rs_ack_ign_vld", o_resp_valid, 0);
        chk("rs_ack_ign_busy", o_busy, 0);
        req(32'h8000_0060, 0, 3'd0, 0, 0);
        serve("rs_ld", 0, L2);
        chk("rs_ld_addr", m_addr, 28'h800_0006);
        chk("rs_ld_data", o_data_data, L2);
        tick();

`ifdef CLUSTER_MEM_LINE_BUF_EN
        req(32'h8000_0100, 0, 3'd2, 0, 0);
        serve("lb1", 0, L1);
        chk("lb1_data", o_data_data, L1);
        tick();
        req(32'h8000_0104, 0, 3'd2, 0, 1);
        chk("lb_hit_memreq", o_mem_req, 0);
        chk("lb_hit_vld", o_resp_valid, 1);
        chk("lb_hit_insn", o_insn_data, L1);
        tick();
        i_buf_flush = 1'b1;
        tick();
        i_buf_flush = 1'b0;
        req(32'h8000_0108, 0, 3'd2, 0, 0);
        chk("lb_flush_memreq", o_mem_req, 1);
        serve("lb3", 0, L2);
        chk("lb3_data", o_data_data, L2);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
